beta_alu_mc: RTL

- Parametrised, multicycle successor to the Beta datapath ALU.
- Generalised operand width; registered valid/ready handshake on both sides.
- Iterative shift-add multiplier; signed and unsigned compares; an error flag.
- Sits between the register-file read stage and writeback. The stall logic uses in_ready/out_valid so MUL can take WIDTH cycles without a combinational multiplier.

---
 rtl/beta_alu_mc.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/beta_alu_mc.sv
// Multicycle Beta ALU with valid/ready handshakes on both sides, single-cycle
// arith/logic/compare/shift ops and an iterative shift-add MUL.
// Define BETA_ALU_DIV_EN to add an iterative unsigned restoring divide on opcode 0011.
module beta_alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_fn,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000, OP_SUB   = 4'b0001, OP_MUL   = 4'b0010, OP_DIV   = 4'b0011,
    OP_CMPEQ = 4'b0100, OP_CMPLT = 4'b0101, OP_CMPLE = 4'b0110, OP_CMPLTU = 4'b0111,
    OP_AND   = 4'b1000, OP_OR    = 4'b1001, OP_XOR   = 4'b1010, OP_XNOR  = 4'b1011,
    OP_SHL   = 4'b1100, OP_SHR   = 4'b1101, OP_SRA   = 4'b1110, OP_ILL   = 4'b1111
  } alu_op_t;

  typedef enum logic {IDLE, ITER} state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, err_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [SHW-1:0]   cnt_q;

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sc_res;
  logic             sc_err, start_mul, start_div, start_iter;
  logic             accept, last;
  logic [WIDTH-1:0] mul_acc, iter_res;

  assign sh       = in_b[SHW-1:0];
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt_q == SHW'(WIDTH - 1));

  // Single-cycle result path, plus decode of the ops that need the iterator.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    sc_res    = '0;
    sc_err    = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (alu_fn)
      OP_ADD:    sc_res = in_a + in_b;
      OP_SUB:    sc_res = in_a - in_b;
      OP_MUL:    start_mul = 1'b1;
`ifdef BETA_ALU_DIV_EN
      OP_DIV: begin
        if (in_b == '0) begin
          sc_res = '1;
          sc_err = 1'b1;
        end else begin
          start_div = 1'b1;
        end
      end
`else
      OP_DIV:    sc_err = 1'b1;
`endif
      OP_CMPEQ:  sc_res[0] = (in_a == in_b);
      OP_CMPLT:  sc_res[0] = ($signed(in_a) <  $signed(in_b));
      OP_CMPLE:  sc_res[0] = ($signed(in_a) <= $signed(in_b));
      OP_CMPLTU: sc_res[0] = (in_a < in_b);
      OP_AND:    sc_res = in_a & in_b;
      OP_OR:     sc_res = in_a | in_b;
      OP_XOR:    sc_res = in_a ^ in_b;
      OP_XNOR:   sc_res = ~(in_a ^ in_b);
      OP_SHL:    sc_res = in_a << sh;
      OP_SHR:    sc_res = in_a >> sh;
      OP_SRA:    sc_res = $unsigned($signed(in_a) >>> sh);
      default:   sc_err = 1'b1;
    endcase
  end

  assign start_iter = start_mul | start_div;

  // One multiplier bit per iteration: add A<<i when B[i] is set.
  assign mul_acc = acc_q + (b_q[cnt_q] ? (a_q << cnt_q) : '0);

`ifdef BETA_ALU_DIV_EN
  // Restoring divide: acc_q holds the partial remainder, a_q shifts the dividend
  // out at the top while quotient bits shift in at the bottom.
  logic             div_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next, quo_next;

  always_comb begin
    trial    = {acc_q, a_q[WIDTH-1]} - {1'b0, b_q};
    rem_next = trial[WIDTH] ? {acc_q[WIDTH-2:0], a_q[WIDTH-1]} : trial[WIDTH-1:0];
    quo_next = {a_q[WIDTH-2:0], ~trial[WIDTH]};
    iter_res = div_q ? quo_next : mul_acc;
  end
`else
  assign iter_res = mul_acc;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && start_iter) state_d = ITER;
      ITER:    if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`ifdef BETA_ALU_DIV_EN
      div_q       <= 1'b0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;

      if (accept) begin
        if (start_iter) begin
          a_q   <= in_a;
          b_q   <= in_b;
          acc_q <= '0;
          cnt_q <= '0;
`ifdef BETA_ALU_DIV_EN
          div_q <= start_div;
`endif
        end else begin
          result_q    <= sc_res;
          err_q       <= sc_err;
          out_valid_q <= 1'b1;
        end
      end

      if (state_q == ITER) begin
        cnt_q <= cnt_q + SHW'(1);
`ifdef BETA_ALU_DIV_EN
        if (div_q) begin
          acc_q <= rem_next;
          a_q   <= quo_next;
        end else begin
          acc_q <= mul_acc;
        end
`else
        acc_q <= mul_acc;
`endif
        if (last) begin
          result_q    <= iter_res;
          err_q       <= 1'b0;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;
  assign busy      = (state_q == ITER);

endmodule
